// File: rtl/crtc_init_seq.sv
// Loads a 16-register CPC CRTC preset (50/60 Hz) on START: one register per two clocks, 34 cycles from START to DONE.
// Owns the CRTC port for 33 cycles (BUSY/CPU_WAIT); CPU data writes meanwhile are dropped, select writes are still tracked.
module crtc_init_seq (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic       PRESET,
  input  logic       CPU_ENABLE,
  input  logic       CPU_nCS,
  input  logic       CPU_R_nW,
  input  logic       CPU_RS,
  input  logic [7:0] CPU_DI,
  output logic       ENABLE,
  output logic       nCS,
  output logic       R_nW,
  output logic       RS,
  output logic [7:0] DI,
  output logic       BUSY,
  output logic       CPU_WAIT,
  output logic       DONE,
  output logic       DROPPED
);

  typedef enum logic [2:0] {ST_IDLE, ST_SEL, ST_DATA, ST_RESTORE, ST_FINISH} state_t;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic       preset_q;
  logic [4:0] shadow_sel;
  logic       dropped_q;
  logic       cpu_sel_wr, cpu_dat_wr;

  function automatic logic [7:0] preset_val(input logic hz60, input logic [3:0] r);
    case (r)
      4'd0:    preset_val = 8'd63;
      4'd1:    preset_val = 8'd40;
      4'd2:    preset_val = 8'd46;
      4'd3:    preset_val = 8'd142;
      4'd4:    preset_val = hz60 ? 8'd31 : 8'd38;
      4'd6:    preset_val = 8'd25;
      4'd7:    preset_val = hz60 ? 8'd27 : 8'd30;
      4'd9:    preset_val = 8'd7;
      4'd12:   preset_val = 8'd48;
      default: preset_val = 8'd0;
    endcase
  endfunction

  assign cpu_sel_wr = CPU_ENABLE & ~CPU_nCS & ~CPU_R_nW & ~CPU_RS;
  assign cpu_dat_wr = CPU_ENABLE & ~CPU_nCS & ~CPU_R_nW &  CPU_RS;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      idx        <= 4'd0;
      preset_q   <= 1'b0;
      shadow_sel <= 5'd0;
      dropped_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == ST_IDLE && START) begin
        preset_q  <= PRESET;
        dropped_q <= 1'b0;
      end else if (BUSY && cpu_dat_wr) begin
        dropped_q <= 1'b1;
      end
      // Select writes are shadowed even while stalled so RESTORE puts back the latest one
      if (cpu_sel_wr) shadow_sel <= CPU_DI[4:0];
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ENABLE    = CPU_ENABLE;
    nCS       = CPU_nCS;
    R_nW      = CPU_R_nW;
    RS        = CPU_RS;
    DI        = CPU_DI;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt = ST_SEL;
          idx_nxt   = 4'd0;
        end
      end
      ST_SEL: begin
        BUSY      = 1'b1;
        ENABLE    = 1'b1;
        nCS       = 1'b0;
        R_nW      = 1'b0;
        RS        = 1'b0;
        DI        = {4'b0, idx};
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        BUSY   = 1'b1;
        ENABLE = 1'b1;
        nCS    = 1'b0;
        R_nW   = 1'b0;
        RS     = 1'b1;
        DI     = preset_val(preset_q, idx);
        if (idx == 4'd15) begin
          state_nxt = ST_RESTORE;
          idx_nxt   = 4'd0;
        end else begin
          state_nxt = ST_SEL;
          idx_nxt   = idx + 4'd1;
        end
      end
      ST_RESTORE: begin
        BUSY      = 1'b1;
        ENABLE    = 1'b1;
        nCS       = 1'b0;
        R_nW      = 1'b0;
        RS        = 1'b0;
        DI        = {3'b0, shadow_sel};
        state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        DONE      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign CPU_WAIT = BUSY;
  assign DROPPED  = dropped_q;

endmodule

// File: tb/tb_crtc_init_seq.sv
// Bench for crtc_init_seq: queue-based reference model of the loader plus a small CRTC register model.
module tb_crtc_init_seq;

  logic       CLOCK, RESET, START, PRESET;
  logic       CPU_ENABLE, CPU_nCS, CPU_R_nW, CPU_RS;
  logic [7:0] CPU_DI;
  logic       ENABLE, nCS, R_nW, RS;
  logic [7:0] DI;
  logic       BUSY, CPU_WAIT, DONE, DROPPED;

  crtc_init_seq dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .PRESET(PRESET),
    .CPU_ENABLE(CPU_ENABLE), .CPU_nCS(CPU_nCS), .CPU_R_nW(CPU_R_nW), .CPU_RS(CPU_RS),
    .CPU_DI(CPU_DI),
    .ENABLE(ENABLE), .nCS(nCS), .R_nW(R_nW), .RS(RS), .DI(DI),
    .BUSY(BUSY), .CPU_WAIT(CPU_WAIT), .DONE(DONE), .DROPPED(DROPPED)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  int t50[16] = '{63, 40, 46, 142, 38, 0, 25, 30, 0, 7, 0, 0, 48, 0, 0, 0};
  int t60[16] = '{63, 40, 46, 142, 31, 0, 25, 27, 0, 7, 0, 0, 48, 0, 0, 0};

  // Reference model: pending loader bus writes; -1 marks the restore of the CPU's select
  int         q[$];
  bit         done_pend;
  logic [4:0] shadow;
  bit         dropped;
  bit         model_valid = 1'b0;

  logic [7:0] crtc_reg [32];
  logic [4:0] crtc_addr;

  logic last_done, last_busy, last_dropped;
  logic [3:0] last_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cpu(input logic en, input logic ncs, input logic rnw, input logic rs, input logic [7:0] d);
    CPU_ENABLE = en; CPU_nCS = ncs; CPU_R_nW = rnw; CPU_RS = rs; CPU_DI = d;
  endtask

  task automatic cycle();
    logic [14:0] exp, act;
    int  item;
    logic rs_e;
    logic [7:0] di_e;
    bit busy_m, accept;
    @(negedge CLOCK);
    if (q.size() > 0) begin
      item = q[0];
      if (item < 0) begin rs_e = 1'b0; di_e = {3'b0, shadow}; end
      else begin rs_e = (item >= 256); di_e = item[7:0]; end
      exp = {3'b100, rs_e, di_e, 1'b1, 1'b1, 1'b0, dropped};
    end else begin
      exp = {CPU_ENABLE, CPU_nCS, CPU_R_nW, CPU_RS, CPU_DI, 1'b0, 1'b0, done_pend, dropped};
    end
    act = {ENABLE, nCS, R_nW, RS, DI, BUSY, CPU_WAIT, DONE, DROPPED};
    if (model_valid) check("bus", {17'd0, act}, {17'd0, exp});
    last_done = DONE; last_busy = BUSY; last_dropped = DROPPED;
    last_flags = {BUSY, CPU_WAIT, DONE, DROPPED};
    if (ENABLE === 1'b1 && nCS === 1'b0 && R_nW === 1'b0) begin
      if (RS) crtc_reg[crtc_addr] = DI;
      else    crtc_addr = DI[4:0];
    end
    @(posedge CLOCK);
    if (RESET) begin
      q.delete(); done_pend = 0; shadow = 5'd0; dropped = 0; model_valid = 1'b1;
    end else begin
      busy_m = (q.size() > 0);
      accept = !busy_m && !done_pend && START;
      if (CPU_ENABLE && !CPU_nCS && !CPU_R_nW && !CPU_RS) shadow = CPU_DI[4:0];
      if (busy_m && CPU_ENABLE && !CPU_nCS && !CPU_R_nW && CPU_RS) dropped = 1;
      if (busy_m) begin
        done_pend = (q.size() == 1);
        void'(q.pop_front());
      end else begin
        done_pend = 0;
        if (accept) begin
          dropped = 0;
          for (int r = 0; r < 16; r++) begin
            q.push_back(r);
            q.push_back(256 + (PRESET ? t60[r] : t50[r]));
          end
          q.push_back(-1);
        end
      end
    end
    #1;
  endtask

  // Runs until DONE is seen; returns the cycle count after the START cycle (0 on timeout)
  task automatic run_to_done(output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      cycle();
      if (last_done === 1'b1) begin n = i; break; end
    end
  endtask

  typedef struct {
    logic en, ncs, rnw, rs;
    logic [7:0] di;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[7];
  int n, dones, aa_cnt;

  initial begin
    for (int i = 0; i < 32; i++) crtc_reg[i] = 8'h00;
    crtc_addr = 5'd0;
    last_done = 0; last_busy = 0; last_dropped = 0; last_flags = 4'h0;
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, {4'b0110, 8'h00, 1'b0}};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, {4'b1011, 8'hA5, 1'b0}};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h0E, {4'b1000, 8'h0E, 1'b0}};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, {4'b1001, 8'h3C, 1'b0}};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, {4'b0000, 8'hFF, 1'b0}};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h81, {4'b1101, 8'h81, 1'b0}};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, {4'b1000, 8'h00, 1'b0}};

    RESET = 1'b1; START = 1'b0; PRESET = 1'b0;
    cpu(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    cycle();
    RESET = 1'b0;
    cycle();
    check("reset_flags", {28'd0, last_flags}, 32'd0);

    // IDLE passthrough vectors
    foreach (vecs[i]) begin
      cpu(vecs[i].en, vecs[i].ncs, vecs[i].rnw, vecs[i].rs, vecs[i].di);
      #2;
      check("vec_pass", {19'd0, ENABLE, nCS, R_nW, RS, DI, BUSY}, {19'd0, vecs[i].exp});
      cycle();
    end
    cpu(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

    // 50 Hz load
    START = 1'b1; PRESET = 1'b0;
    cycle();
    START = 1'b0;
    run_to_done(n);
    check("done_latency_50", n, 34);
    check("r4_50", crtc_reg[4], 38);
    check("r7_50", crtc_reg[7], 30);
    check("restore_addr_0", crtc_addr, 0);

    // Select R14, then 60 Hz load
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 8'd14);
    cycle();
    cpu(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    START = 1'b1; PRESET = 1'b1;
    cycle();
    START = 1'b0;
    run_to_done(n);
    check("done_latency_60", n, 34);
    check("r4_60", crtc_reg[4], 31);
    check("r7_60", crtc_reg[7], 27);
    check("restore_addr_14", crtc_addr, 14);
    cpu(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    cycle();
    check("read_r14", crtc_reg[crtc_addr], 0);
    cpu(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

    // Select 12 and data write 0xAA while busy
    START = 1'b1; PRESET = 1'b0;
    cycle();
    START = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 8'd12);
    cycle();
    cpu(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
    cycle();
    cpu(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    run_to_done(n);
    check("done_latency_drop", n, 27);
    check("dropped_set", last_dropped, 1);
    check("restore_addr_12", crtc_addr, 12);
    check("r12_kept", crtc_reg[12], 48);
    aa_cnt = 0;
    for (int i = 0; i < 32; i++) if (crtc_reg[i] == 8'hAA) aa_cnt++;
    check("aa_not_forwarded", aa_cnt, 0);

    // START re-pulsed mid-load is ignored; acceptance clears DROPPED
    START = 1'b1;
    cycle();
    START = 1'b0;
    check("dropped_cleared", DROPPED, 0);
    dones = 0;
    for (int i = 1; i <= 45; i++) begin
      START = (i == 10);
      cycle();
      if (last_done === 1'b1) dones++;
    end
    START = 1'b0;
    check("single_done", dones, 1);

    // RESET mid-load
    START = 1'b1;
    cycle();
    START = 1'b0;
    for (int i = 0; i < 14; i++) cycle();
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    cycle();
    check("busy_after_reset", last_busy, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_done === 1'b1) dones++;
    end
    check("no_done_after_reset", dones, 0);
    cpu(1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
    #2;
    check("pass_after_reset", {ENABLE, nCS, R_nW, RS, DI}, {4'b1011, 8'h5A});
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cpu($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), 8'($urandom));
      START  = ($urandom_range(0, 19) == 0);
      PRESET = $urandom_range(0, 1);
      RESET  = ($urandom_range(0, 96) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
